// File: rtl/shift_reg_seq.sv
// Sequential shifter/register: LOAD/CLR/NOP in one edge, shifts and rotates one bit per edge.
// start is taken only in IDLE; busy covers the remaining N-1 steps, done pulses once after the last update.
module shift_reg_seq #(
  parameter int WIDTH   = 8,
  parameter int SHAMT_W = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [2:0]         op,
  input  logic [SHAMT_W-1:0] amt,
  input  logic [WIDTH-1:0]   d,
  input  logic               serial_in,
  output logic [WIDTH-1:0]   q,
  output logic               serial_out,
  output logic               busy,
  output logic               done
);

  typedef enum logic [2:0] {
    OP_NOP  = 3'b000,
    OP_LOAD = 3'b001,
    OP_LSL  = 3'b010,
    OP_LSR  = 3'b011,
    OP_ASR  = 3'b100,
    OP_ROL  = 3'b101,
    OP_ROR  = 3'b110,
    OP_CLR  = 3'b111
  } op_e;

  typedef enum logic {
    S_IDLE,
    S_SHIFT
  } state_e;

  state_e             state_q, state_d;
  op_e                op_q, op_d;
  logic [SHAMT_W-1:0] rem_q, rem_d;
  logic [WIDTH-1:0]   q_q, q_d;
  logic               so_q, so_d;
  logic               done_q, done_d;

  op_e                step_op;
  logic [WIDTH:0]     stepped;

  // One-bit step, packed as {bit shifted out, new register value}.
  function automatic logic [WIDTH:0] step1(input op_e o, input logic [WIDTH-1:0] v,
                                           input logic si);
    case (o)
      OP_LSL:  step1 = {v[WIDTH-1], v[WIDTH-2:0], si};
      OP_LSR:  step1 = {v[0], si, v[WIDTH-1:1]};
      OP_ASR:  step1 = {v[0], v[WIDTH-1], v[WIDTH-1:1]};
      OP_ROL:  step1 = {v[WIDTH-1], v[WIDTH-2:0], v[WIDTH-1]};
      OP_ROR:  step1 = {v[0], v[0], v[WIDTH-1:1]};
      default: step1 = {1'b0, v};
    endcase
  endfunction

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    rem_d   = rem_q;
    q_d     = q_q;
    so_d    = so_q;
    done_d  = 1'b0;
    // The first step of a shift uses the incoming opcode; later steps use the latched one.
    step_op = (state_q == S_IDLE) ? op_e'(op) : op_q;
    stepped = step1(step_op, q_q, serial_in);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d   = op_e'(op);
          done_d = 1'b1;
          case (op_e'(op))
            OP_NOP: ;
            OP_LOAD: q_d = d;
            OP_CLR: begin
              q_d  = '0;
              so_d = 1'b0;
            end
            default: begin
              if (amt != '0) begin
                {so_d, q_d} = stepped;
                if (amt != SHAMT_W'(1)) begin
                  done_d  = 1'b0;
                  state_d = S_SHIFT;
                  rem_d   = amt - SHAMT_W'(1);
                end
              end
            end
          endcase
        end
      end
      S_SHIFT: begin
        {so_d, q_d} = stepped;
        rem_d       = rem_q - SHAMT_W'(1);
        if (rem_q == SHAMT_W'(1)) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      op_q    <= OP_NOP;
      rem_q   <= '0;
      q_q     <= '0;
      so_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      rem_q   <= rem_d;
      q_q     <= q_d;
      so_q    <= so_d;
      done_q  <= done_d;
    end
  end

  assign q          = q_q;
  assign serial_out = so_q;
  assign busy       = (state_q == S_SHIFT);
  assign done       = done_q;

endmodule

// File: tb/tb_shift_reg_seq.sv
// Bench for shift_reg_seq: directed scenarios plus randomized back-to-back commands
// checked against a whole-command arithmetic model.
module tb_shift_reg_seq;
  localparam int W  = 8;
  localparam int SW = 3;

  localparam logic [2:0] NOP = 3'd0, LOAD = 3'd1, LSL = 3'd2, LSR = 3'd3;
  localparam logic [2:0] ASR = 3'd4, ROL = 3'd5, ROR = 3'd6, CLR = 3'd7;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [2:0]    op = 3'd0;
  logic [SW-1:0] amt = '0;
  logic [W-1:0]  d = '0;
  logic          serial_in = 1'b0;
  logic [W-1:0]  q;
  logic          serial_out;
  logic          busy;
  logic          done;

  int errors = 0;
  int checks = 0;

  int   mq;
  logic mso;

  shift_reg_seq #(.WIDTH(W), .SHAMT_W(SW)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .amt(amt), .d(d),
    .serial_in(serial_in), .q(q), .serial_out(serial_out), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish before 200000");
    $fatal(1);
  end

  // Drives a start for one edge and returns at the following falling edge.
  task automatic drive_cmd(input logic [2:0] o, input logic [SW-1:0] a,
                           input logic [W-1:0] dv, input logic si);
    start = 1'b1; op = o; amt = a; d = dv; serial_in = si;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Whole-command result: f[i] is the serial_in seen at the (i+1)-th shift edge.
  function automatic void ref_cmd(input logic [2:0] o, input int a, input logic [W-1:0] dv,
                                  input logic [7:0] f);
    int n, fill, nq;
    nq = mq;
    n  = a;
    case (o)
      NOP: ;
      LOAD: nq = dv;
      CLR: begin nq = 0; mso = 1'b0; end
      default: begin
        if (n != 0) begin
          case (o)
            LSL: begin
              fill = 0;
              for (int i = 0; i < n; i++) fill = (fill << 1) | int'(f[i]);
              nq = ((mq << n) | fill) & 255;
              mso = mq[W-n];
            end
            LSR: begin
              fill = 0;
              for (int i = 0; i < n; i++) fill = fill | (int'(f[i]) << i);
              nq = (mq >> n) | (fill << (W - n));
              mso = mq[n-1];
            end
            ASR: begin
              nq = (mq >> n) | (mq[7] ? ((255 << (W - n)) & 255) : 0);
              mso = mq[n-1];
            end
            ROL: begin
              nq = ((mq << n) | (mq >> (W - n))) & 255;
              mso = mq[W-n];
            end
            default: begin
              nq = ((mq >> n) | (mq << (W - n))) & 255;
              mso = mq[n-1];
            end
          endcase
        end
      end
    endcase
    mq = nq & 255;
  endfunction

  task automatic test_reset();
    #1;
    checks++; if (q !== 8'h00) begin errors++; $display("FAIL reset_q: q=%h expected 00", q); end
    checks++; if ({busy, done, serial_out} !== 3'b000) begin errors++;
      $display("FAIL reset_flags: busy/done/so=%b expected 000", {busy, done, serial_out}); end
    @(negedge clk);
    reset = 1'b0;
    drive_cmd(LOAD, 3'd0, 8'hFF, 1'b0);
    drive_cmd(ASR, 3'd5, 8'h00, 1'b0);
    @(posedge clk);
    #2;
    checks++; if (busy !== 1'b1 || serial_out !== 1'b1) begin errors++;
      $display("FAIL reset_pre: busy=%b so=%b expected 1 1", busy, serial_out); end
    reset = 1'b1;
    #1;
    checks++; if (q !== 8'h00) begin errors++; $display("FAIL reset_async_q: q=%h expected 00", q); end
    checks++; if ({busy, done, serial_out} !== 3'b000) begin errors++;
      $display("FAIL reset_async_flags: busy/done/so=%b expected 000", {busy, done, serial_out}); end
    @(negedge clk);
    reset = 1'b0;
    drive_cmd(LOAD, 3'd0, 8'h5A, 1'b0);
    checks++; if (q !== 8'h5A || done !== 1'b1) begin errors++;
      $display("FAIL reset_after: q=%h done=%b expected 5a 1", q, done); end
  endtask

  task automatic test_load();
    drive_cmd(LOAD, 3'd0, 8'hA5, 1'b0);
    checks++; if (q !== 8'hA5) begin errors++; $display("FAIL load_q: q=%h expected a5", q); end
    checks++; if (done !== 1'b1 || busy !== 1'b0) begin errors++;
      $display("FAIL load_flags: done=%b busy=%b expected 1 0", done, busy); end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL load_done_pulse: done=%b expected 0", done); end
  endtask

  task automatic test_lsl();
    drive_cmd(LSL, 3'd3, 8'h00, 1'b1);
    checks++; if (q !== 8'h4B || busy !== 1'b1 || done !== 1'b0) begin errors++;
      $display("FAIL lsl_step1: q=%h busy=%b done=%b expected 4b 1 0", q, busy, done); end
    @(negedge clk);
    checks++; if (q !== 8'h97 || busy !== 1'b1 || done !== 1'b0) begin errors++;
      $display("FAIL lsl_step2: q=%h busy=%b done=%b expected 97 1 0", q, busy, done); end
    @(negedge clk);
    checks++; if (q !== 8'h2F || busy !== 1'b0 || done !== 1'b1 || serial_out !== 1'b1) begin errors++;
      $display("FAIL lsl_step3: q=%h busy=%b done=%b so=%b expected 2f 0 1 1", q, busy, done, serial_out); end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL lsl_done_pulse: done=%b expected 0", done); end
  endtask

  task automatic test_asr();
    drive_cmd(LOAD, 3'd0, 8'h96, 1'b0);
    drive_cmd(ASR, 3'd4, 8'h00, 1'b0);
    repeat (3) @(negedge clk);
    checks++; if (q !== 8'hF9 || serial_out !== 1'b0 || done !== 1'b1) begin errors++;
      $display("FAIL asr: q=%h so=%b done=%b expected f9 0 1", q, serial_out, done); end
  endtask

  task automatic test_ror_max();
    drive_cmd(LOAD, 3'd0, 8'h81, 1'b0);
    drive_cmd(ROR, 3'd7, 8'h00, 1'b0);
    @(negedge clk);
    start = 1'b1; op = CLR; amt = 3'd2; d = 8'hFF;
    @(negedge clk);
    start = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ror_busy: busy=%b expected 1", busy); end
    repeat (4) @(negedge clk);
    checks++; if (q !== 8'h03 || done !== 1'b1 || busy !== 1'b0 || serial_out !== 1'b0) begin errors++;
      $display("FAIL ror_max: q=%h done=%b busy=%b so=%b expected 03 1 0 0", q, done, busy, serial_out); end
  endtask

  task automatic test_back_to_back();
    drive_cmd(LOAD, 3'd0, 8'h9E, 1'b0);
    drive_cmd(LSL, 3'd1, 8'h00, 1'b0);
    checks++; if (q !== 8'h3C || serial_out !== 1'b1 || done !== 1'b1) begin errors++;
      $display("FAIL lsl1: q=%h so=%b done=%b expected 3c 1 1", q, serial_out, done); end
    drive_cmd(LSR, 3'd0, 8'h00, 1'b1);
    checks++; if (q !== 8'h3C || serial_out !== 1'b1 || done !== 1'b1 || busy !== 1'b0) begin errors++;
      $display("FAIL lsr_amt0: q=%h so=%b done=%b busy=%b expected 3c 1 1 0", q, serial_out, done, busy); end
    drive_cmd(CLR, 3'd0, 8'h00, 1'b0);
    checks++; if (q !== 8'h00 || serial_out !== 1'b0 || done !== 1'b1) begin errors++;
      $display("FAIL clr_b2b: q=%h so=%b done=%b expected 00 0 1", q, serial_out, done); end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL clr_done_pulse: done=%b expected 0", done); end
  endtask

  task automatic test_random();
    logic [2:0] o;
    logic [2:0] a;
    logic [7:0] dv;
    logic [7:0] f;
    int n;
    mq  = 0;
    mso = 1'b0;
    for (int c = 0; c < 80; c++) begin
      o  = 3'($urandom_range(0, 7));
      a  = 3'($urandom_range(0, 7));
      dv = 8'($urandom_range(0, 255));
      f  = '0;
      n  = (o >= LSL && o <= ROR && a != 3'd0) ? int'(a) : 1;
      start = 1'b1; op = o; amt = a; d = dv;
      for (int e = 0; e < n; e++) begin
        f[e] = 1'($urandom_range(0, 1));
        serial_in = f[e];
        if (e > 0) begin
          start = 1'($urandom_range(0, 1));
          op    = 3'($urandom_range(0, 7));
          amt   = 3'($urandom_range(0, 7));
          d     = 8'($urandom_range(0, 255));
        end
        @(posedge clk);
        @(negedge clk);
        if (e < n - 1) begin
          checks++; if (busy !== 1'b1 || done !== 1'b0) begin errors++;
            $display("FAIL rand_busy c=%0d step=%0d: busy=%b done=%b expected 1 0", c, e, busy, done); end
        end
      end
      start = 1'b0;
      ref_cmd(o, int'(a), dv, f);
      checks++; if (q !== mq[7:0] || serial_out !== mso) begin errors++;
        $display("FAIL rand_result c=%0d op=%0d amt=%0d: q=%h so=%b expected %h %b",
                 c, o, a, q, serial_out, mq[7:0], mso); end
      checks++; if (done !== 1'b1 || busy !== 1'b0) begin errors++;
        $display("FAIL rand_done c=%0d: done=%b busy=%b expected 1 0", c, done, busy); end
      if ($urandom_range(0, 3) == 0) begin
        @(negedge clk);
        checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++;
          $display("FAIL rand_idle c=%0d: done=%b busy=%b expected 0 0", c, done, busy); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_lsl();
    test_asr();
    test_ror_max();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
